// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, data width and initiator FSM states.
package axil_pkg;

    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_REQ   = 3'd1,
        S_WR_RESP  = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_DATA  = 3'd4,
        S_DONE     = 3'd5
    } axil_state_t;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one response out.
// Accept-to-rsp_valid is 3 cycles with ready slaves; every stage waits on its handshake and holds its outputs.
module axil_master
    import axil_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_W-1:0]          cmd_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AXI_DATA_W-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [AXI_DATA_W-1:0]          wdata,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    output logic                           bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] araddr,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [AXI_DATA_W-1:0]          rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rvalid,
    output logic                           rready
);

    axil_state_t                    r_state;
    axil_state_t                    w_next_state;
    logic                           r_aw_done;
    logic                           r_w_done;
    logic [AXI_LITE_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_W-1:0]          r_wdata;
    logic [AXI_DATA_W-1:0]          r_rdata;
    logic [1:0]                     r_resp;

    logic w_cmd_fire;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_ok;
    logic w_w_ok;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_aw_fire  = awvalid && awready;
    assign w_w_fire   = wvalid && wready;
    assign w_aw_ok    = r_aw_done || w_aw_fire;
    assign w_w_ok     = r_w_done || w_w_fire;

    assign awaddr    = r_addr;
    assign araddr    = r_addr;
    assign wdata     = r_wdata;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Valids decode from registered state and done flags only, never from AXI inputs.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_aw_ok && w_w_ok) begin
                    w_next_state = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_RD_REQ: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next_state = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // AW and W complete independently; flags clear once both are through.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_WR_REQ && !(w_aw_ok && w_w_ok)) begin
            r_aw_done <= w_aw_ok;
            r_w_done  <= w_w_ok;
        end else begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_resp  <= AXI_OK;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= cmd_addr;
                if (cmd_write) begin
                    r_wdata <= cmd_wdata;
                end
            end
            if (r_state == S_WR_RESP && bvalid) begin
                r_rdata <= '0;
                r_resp  <= bresp;
            end
            if (r_state == S_RD_DATA && rvalid) begin
                r_rdata <= rdata;
                r_resp  <= rresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: behavioural memory slave with per-channel ready/response delays,
// response scoreboard, handshake monitors and directed corner cases.
module tb_axil_master;
    import axil_pkg::*;

    localparam int AW = 8;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;

    always #5 aclk = ~aclk;

    axil_master #(.AXI_LITE_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Slave knobs, written only by the stimulus process.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic        force_rd = 1'b0;
    logic [31:0] force_rdata = '0;
    logic [1:0]  force_rresp = AXI_OK;
    logic [1:0]  bresp_val = AXI_OK;

    // Behavioural slave: ready rises after <delay> cycles of valid.
    logic [31:0]   mem [64];
    int            aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic          s_aw_got, s_w_got, r_pend;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [31:0]   s_wdata;
    logic [AW-1:0] wr_a;
    logic [31:0]   wr_d;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);
    assign wr_a    = (awvalid && awready) ? awaddr : s_awaddr;
    assign wr_d    = (wvalid && wready) ? wdata : s_wdata;

    always @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
            bvalid <= 1'b0; bresp <= AXI_OK;
            rvalid <= 1'b0; rdata <= '0; rresp <= AXI_OK;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; end
            if (wvalid && wready) begin s_w_got <= 1'b1; s_wdata <= wdata; end
            if (bvalid && bready) bvalid <= 1'b0;
            if ((s_aw_got || (awvalid && awready)) && (s_w_got || (wvalid && wready)) && !bvalid) begin
                mem[wr_a[7:2]] <= wr_d;
                bvalid   <= 1'b1;
                bresp    <= bresp_val;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_delay == 0) begin
                    rvalid <= 1'b1;
                    rdata  <= force_rd ? force_rdata : mem[araddr[7:2]];
                    rresp  <= force_rd ? force_rresp : AXI_OK;
                end else begin
                    r_pend   <= 1'b1;
                    r_cnt    <= 1;
                    s_araddr <= araddr;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    r_pend <= 1'b0;
                    rvalid <= 1'b1;
                    rdata  <= force_rd ? force_rdata : mem[s_araddr[7:2]];
                    rresp  <= force_rd ? force_rresp : AXI_OK;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t obs_q[$];

    // Monitor samples on the falling edge, away from DUT updates.
    int   cyc = 0, aw_hi = 0, w_hi = 0, b_hs = 0, rsp_hs = 0, rsp_vld_cnt = 0;
    int   w_hs_cyc = 0, bready_rise_cyc = 0;
    logic bready_q = 1'b0;

    always @(negedge aclk) begin
        cyc = cyc + 1;
        if (awvalid) aw_hi = aw_hi + 1;
        if (wvalid) w_hi = w_hi + 1;
        if (bvalid && bready) b_hs = b_hs + 1;
        if (wvalid && wready) w_hs_cyc = cyc;
        if (bready && !bready_q) bready_rise_cyc = cyc;
        bready_q = bready;
        if (rsp_valid) rsp_vld_cnt = rsp_vld_cnt + 1;
        if (rsp_valid && rsp_ready) begin
            obs_q.push_back('{rdata: rsp_rdata, resp: rsp_resp});
            rsp_hs = rsp_hs + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic [1:0] exp_r, input bit push);
        int t;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        if (push) exp_q.push_back('{rdata: exp_d, resp: exp_r});
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 100) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int   t;
        rsp_t o, e;
        t = 0;
        while (obs_q.size() == 0 && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (obs_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            o = obs_q.pop_front();
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_rdata"}, o.rdata, e.rdata);
            check({tag, "_resp"}, {30'd0, o.resp}, {30'd0, e.resp});
        end
    endtask

    initial begin
        int          lat, a0, w0, b0, bad, v0, t;
        logic [31:0] d0;
        resetn = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge aclk);
        check("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_resp", {30'd0, rsp_resp}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        resetn = 1'b1;

        // Basic write then read-back; latency counts the accept edge as the first.
        issue(1'b1, 8'h08, 32'hDEADBEEF, 32'd0, AXI_OK, 1'b1);
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge aclk); #1; lat++; end
        check("wr_latency", lat, 3);
        wait_rsp("wr08");
        issue(1'b0, 8'h08, 32'd0, 32'hDEADBEEF, AXI_OK, 1'b1);
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge aclk); #1; lat++; end
        check("rd_latency", lat, 3);
        wait_rsp("rd08");

        // Slow AW, immediate W.
        aw_delay = 3;
        a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        issue(1'b1, 8'h0C, 32'hA5A5_0001, 32'd0, AXI_OK, 1'b1);
        wait_rsp("wr_slow_aw");
        check("slow_aw_awvalid_cycles", aw_hi - a0, 4);
        check("slow_aw_wvalid_cycles", w_hi - w0, 1);
        check("slow_aw_b_handshakes", b_hs - b0, 1);
        aw_delay = 0;

        // Slow W, immediate AW.
        w_delay = 5;
        a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        issue(1'b1, 8'h10, 32'h0BAD_F00D, 32'd0, AXI_OK, 1'b1);
        wait_rsp("wr_slow_w");
        check("slow_w_awvalid_cycles", aw_hi - a0, 1);
        check("slow_w_wvalid_cycles", w_hi - w0, 6);
        check("slow_w_bready_after_w", bready_rise_cyc - w_hs_cyc, 1);
        check("slow_w_b_handshakes", b_hs - b0, 1);
        w_delay = 0;
        issue(1'b0, 8'h10, 32'd0, 32'h0BAD_F00D, AXI_OK, 1'b1);
        wait_rsp("rd10");

        // Response backpressure.
        rsp_ready = 1'b0;
        issue(1'b0, 8'h08, 32'd0, 32'hDEADBEEF, AXI_OK, 1'b1);
        t = 0;
        while (!rsp_valid && t < 100) begin @(negedge aclk); t++; end
        check("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        d0 = rsp_rdata;
        bad = 0;
        repeat (10) begin
            @(negedge aclk);
            if (!rsp_valid || rsp_rdata !== d0 || cmd_ready !== 1'b0) bad++;
        end
        check("hold_stable_cycles_bad", bad, 0);
        check("hold_rdata", d0, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        wait_rsp("rd_hold");

        // Reset while waiting in RD_DATA: aborted read must never respond.
        r_delay = 8;
        issue(1'b0, 8'h08, 32'd0, 32'd0, AXI_OK, 1'b0);
        t = 0;
        while (!rready && t < 100) begin @(negedge aclk); t++; end
        check("abort_in_rd_data", {31'd0, rready}, 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        v0 = rsp_vld_cnt;
        @(negedge aclk);
        resetn = 1'b1;
        @(posedge aclk); #1;
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (20) @(negedge aclk);
        check("abort_no_rsp_valid", rsp_vld_cnt - v0, 0);
        r_delay = 0;

        // Error responses pass through unchanged.
        force_rd = 1'b1; force_rdata = 32'h12345678; force_rresp = AXI_ERR;
        issue(1'b0, 8'h20, 32'd0, 32'h12345678, AXI_ERR, 1'b1);
        wait_rsp("rd_slverr");
        force_rdata = 32'hCAFE_0003; force_rresp = 2'b11;
        issue(1'b0, 8'h24, 32'd0, 32'hCAFE_0003, 2'b11, 1'b1);
        wait_rsp("rd_decerr");
        force_rd = 1'b0;
        bresp_val = 2'b11;
        issue(1'b1, 8'h28, 32'h1111_2222, 32'd0, 2'b11, 1'b1);
        wait_rsp("wr_decerr");
        bresp_val = AXI_ERR;
        issue(1'b1, 8'h2C, 32'h3333_4444, 32'd0, AXI_ERR, 1'b1);
        wait_rsp("wr_slverr");

        repeat (5) @(negedge aclk);
        check("leftover_observed", obs_q.size(), 0);
        check("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
